bcd_disp_mux: RTL
=================

BCD_DISP_MUX -- requirements
Module: bcd_disp_mux

Interface
REQ-001 Parameter PRESCALE, default 50000: clock cycles each digit stays lit; legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 bcd_in  input  12  three packed BCD digits {hundreds, tens, ones}, as produced by the BCD incrementor stage.
REQ-005 load  input  1  when high, bcd_in is captured into the display register.
REQ-006 lz_blank  input  1  when high, leading zeros are blanked.
REQ-007 an  output  3  active-low digit enables; an[0] drives the ones digit.
REQ-008 sseg  output  8  active-low segments: sseg[7]=dp, sseg[6:0]=g..a.

Function
REQ-009 The block SHALL hold a 12-bit display register, loaded from bcd_in on any edge where load=1, and otherwise unchanged.
REQ-010 A 20-bit prescale counter SHALL increment every cycle and wrap to 0 after reaching PRESCALE-1.
REQ-011 A 2-bit digit index SHALL advance 0->1->2->0 only on cycles where the prescale counter equals PRESCALE-1; value 3 is unreachable.
REQ-012 an and sseg SHALL be registered, reflecting the digit index and display register as they stood before the same edge (one-cycle latency).
REQ-013 Exactly one an bit SHALL be low outside reset: an[k]=0 iff the registered index = k.
REQ-014 Nibble values 0-9 SHALL decode to standard patterns: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex, dp off).
REQ-015 Nibble values 10-15 SHALL display a dash, 8'hBF.
REQ-016 With lz_blank=1, blanking SHALL output sseg=8'hFF while the digit's an bit is still driven low:
- hundreds blanked when it is 0;
- tens blanked when both hundreds and tens are 0;
- ones never blanked.
REQ-017 An invalid (>9) hundreds or tens nibble SHALL count as non-zero for blanking.
REQ-018 If load=1 arrives during a digit slot, the new value SHALL appear from the next edge at which sseg is updated; the scan timing is undisturbed.
REQ-019 The decimal point SHALL remain off (sseg[7]=1) at all times.

Reset
REQ-020 While reset_n=0 at an edge, the block SHALL set:
- display register = 0, prescale counter = 0, digit index = 0;
- an = 3'b111 and sseg = 8'hFF.
REQ-021 On the first edge with reset_n=1, the block SHALL output an=3'b110 and sseg=8'hC0.
REQ-022 Reset asserted mid-scan SHALL take effect on the next edge regardless of load, and SHALL discard the loaded value.

Structure
REQ-023 The segment constants (digit patterns, SEG_BLANK=8'hFF, SEG_DASH=8'hBF) SHALL reside in the shared package bcd_disp_pkg.
REQ-024 Nibble-to-segment decoding SHALL be the purely combinational sub-module bcd_to_sseg (4-bit in, 8-bit out).
REQ-025 The digit index width and the PRESCALE counter width SHALL be package constants.

Verification (PRESCALE=4)
REQ-026 Reset release, no load -> sequence an=110,101,011, each held 4 cycles, repeating.
- With lz_blank=0: sseg=C0 on every slot.
- With lz_blank=1: ones slot shows C0, tens and hundreds slots show FF.
REQ-027 load with bcd_in=12'h259 (output of incrementing 0x258), lz_blank=0 -> ones=90, tens=92, hundreds=A4.
REQ-028 bcd_in=12'h007, lz_blank=1 -> hundreds=FF, tens=FF, ones=F8; with bcd_in=12'h100 -> hundreds=F9, tens=C0, ones=C0.
REQ-029 bcd_in=12'hA3F, lz_blank=1 -> hundreds=BF, tens=B0, ones=BF.
REQ-030 load of 12'h999 mid-slot of the tens digit -> from the next edge the tens slot shows 90, and the slot boundary is unchanged.
REQ-031 reset_n=0 for one cycle mid-slot -> next edge gives an=111 and sseg=FF, the register is cleared, and scanning restarts at the ones digit.

Source files
------------

// File: rtl/bcd_disp_pkg.sv
// Shared constants and types for the three-digit BCD display scanner.
package bcd_disp_pkg;

    localparam int DIG_W  = 2;   // digit index width
    localparam int CNT_W  = 20;  // prescale counter width
    localparam int DISP_W = 12;  // three packed BCD nibbles

    // Active-low segment patterns, dp (bit 7) always off.
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [2:0] AN_OFF    = 3'b111;

    // Which digit is currently being driven; the fourth code is never entered.
    typedef enum logic [DIG_W-1:0] {
        DIG_ONES  = DIG_W'(0),
        DIG_TENS  = DIG_W'(1),
        DIG_HUNDS = DIG_W'(2)
    } digit_e;

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational nibble-to-seven-segment decoder; non-BCD nibbles show a dash.
module bcd_to_sseg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_sseg
);

    // Map one nibble onto its active-low segment pattern.
    always_comb begin
        o_sseg = SEG_DASH;
        case (i_nibble)
            4'd0:    o_sseg = SEG_0;
            4'd1:    o_sseg = SEG_1;
            4'd2:    o_sseg = SEG_2;
            4'd3:    o_sseg = SEG_3;
            4'd4:    o_sseg = SEG_4;
            4'd5:    o_sseg = SEG_5;
            4'd6:    o_sseg = SEG_6;
            4'd7:    o_sseg = SEG_7;
            4'd8:    o_sseg = SEG_8;
            4'd9:    o_sseg = SEG_9;
            default: o_sseg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_disp_mux.sv
// Three-digit multiplexed seven-segment driver with leading-zero blanking.
//
// state     | meaning
// ----------+--------------------------------------------
// DIG_ONES  | ones digit lit (an[0] low), entered on reset
// DIG_TENS  | tens digit lit (an[1] low)
// DIG_HUNDS | hundreds digit lit (an[2] low)
module bcd_disp_mux
    import bcd_disp_pkg::*;
#(
    parameter int PRESCALE = 50000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DISP_W-1:0] bcd_in,
    input  logic              load,
    input  logic              lz_blank,
    output logic [2:0]        an,
    output logic [7:0]        sseg
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [DISP_W-1:0] r_disp;
    logic [CNT_W-1:0]  r_cnt;
    digit_e            r_dig;

    digit_e            w_dig_nxt;
    logic              w_slot_end;
    logic [3:0]        w_hunds;
    logic [3:0]        w_tens;
    logic [3:0]        w_nibble;
    logic [7:0]        w_dec;
    logic              w_blank;
    logic [2:0]        w_an_nxt;
    logic [7:0]        w_sseg_nxt;

    assign w_hunds    = r_disp[11:8];
    assign w_tens     = r_disp[7:4];
    assign w_slot_end = (r_cnt == CNT_LAST);

    bcd_to_sseg u_dec (
        .i_nibble (w_nibble),
        .o_sseg   (w_dec)
    );

    // Digit sequencing and the output values for the digit currently selected.
    always_comb begin
        w_dig_nxt = r_dig;
        w_nibble  = r_disp[3:0];
        w_an_nxt  = 3'b110;
        w_blank   = 1'b0;
        case (r_dig)
            DIG_TENS: begin
                if (w_slot_end) w_dig_nxt = DIG_HUNDS;
                w_nibble = w_tens;
                w_an_nxt = 3'b101;
                // Invalid nibbles are non-zero, so they keep lower digits visible.
                w_blank  = lz_blank && (w_hunds == 4'd0) && (w_tens == 4'd0);
            end
            DIG_HUNDS: begin
                if (w_slot_end) w_dig_nxt = DIG_ONES;
                w_nibble = w_hunds;
                w_an_nxt = 3'b011;
                w_blank  = lz_blank && (w_hunds == 4'd0);
            end
            default: begin
                if (w_slot_end) w_dig_nxt = DIG_TENS;
            end
        endcase
        w_sseg_nxt = w_blank ? SEG_BLANK : w_dec;
    end

    // State, display register, prescaler and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_disp <= '0;
            r_cnt  <= '0;
            r_dig  <= DIG_ONES;
            an     <= AN_OFF;
            sseg   <= SEG_BLANK;
        end else begin
            if (load) r_disp <= bcd_in;
            r_cnt <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
            r_dig <= w_dig_nxt;
            an    <= w_an_nxt;
            sseg  <= w_sseg_nxt;
        end
    end

endmodule
